traffic_light_ctrl: RTL

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

---
 rtl/tlc_pkg.sv | 27 ++
 rtl/tlc_rr_pick.sv | 38 +++
 rtl/traffic_light_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/tlc_pkg.sv
// +------------------------------------------------------------------+
// | tlc_pkg: shared state encoding, lamp codes and helpers for the   |
// | traffic light controller.                                        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package tlc_pkg;

  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
    S_ALLRED = 2'd2,
    S_WALK   = 2'd3
  } tlc_state_t;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] YELLOW = 3'b001;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tlc_rr_pick.sv
// +------------------------------------------------------------------+
// | tlc_rr_pick: combinational round-robin picker for the approach   |
// | that receives the next green.                                    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tlc_rr_pick #(
  parameter int NUM_DIR = 4
) (
  input  logic [NUM_DIR-1:0]         car_req,
  input  logic [$clog2(NUM_DIR)-1:0] active_dir,
  output logic [$clog2(NUM_DIR)-1:0] next_dir
);

  localparam int DIR_W = $clog2(NUM_DIR);

  logic             found;
  logic [DIR_W-1:0] cand;

  // Search starts one past the current owner and ends on the owner itself;
  // with no request at all the grant simply advances by one.
  always_comb begin
    found    = 1'b0;
    cand     = '0;
    next_dir = (int'(active_dir) == NUM_DIR - 1) ? '0 : active_dir + 1'b1;
    for (int k = 1; k <= NUM_DIR; k++) begin
      cand = DIR_W'((int'(active_dir) + k) % NUM_DIR);
      if (!found && car_req[cand]) begin
        next_dir = cand;
        found    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
// +------------------------------------------------------------------+
// | traffic_light_ctrl: round-robin intersection controller with     |
// | minimum green, yellow and all-red clearance; optional pedestrian |
// | walk phase enabled by macro TLC_PED_EN.                          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module traffic_light_ctrl
  import tlc_pkg::*;
#(
  parameter int NUM_DIR    = 4,
  parameter int GREEN_CYC  = 20,
  parameter int YELLOW_CYC = 4,
  parameter int ALLRED_CYC = 2,
  parameter int WALK_CYC   = 10
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_DIR-1:0]         car_req,
`ifdef TLC_PED_EN
  input  logic                       ped_req,
  output logic                       ped_walk,
`endif
  output logic [3*NUM_DIR-1:0]       light,
  output logic [$clog2(NUM_DIR)-1:0] active_dir
);

  localparam int DIR_W   = $clog2(NUM_DIR);
  localparam int MAX_DUR = max_int(max_int(GREEN_CYC, YELLOW_CYC),
                                   max_int(ALLRED_CYC, WALK_CYC));
  localparam int TMR_W   = $clog2(MAX_DUR + 1);

  localparam logic [TMR_W-1:0] GREEN_LD  = TMR_W'(GREEN_CYC - 1);
  localparam logic [TMR_W-1:0] YELLOW_LD = TMR_W'(YELLOW_CYC - 1);
  localparam logic [TMR_W-1:0] ALLRED_LD = TMR_W'(ALLRED_CYC - 1);

  tlc_state_t         state;
  logic [TMR_W-1:0]   timer;
  logic [DIR_W-1:0]   next_dir;
  logic [NUM_DIR-1:0] others;
  logic               ped_pend;

  function automatic logic [3*NUM_DIR-1:0] lamp(input logic [DIR_W-1:0] dir,
                                                 input logic [2:0]       color);
    lamp = '0;
    for (int i = 0; i < NUM_DIR; i++)
      lamp[3*i +: 3] = (i == int'(dir)) ? color : RED;
  endfunction

  assign others = car_req & ~(NUM_DIR'(1) << active_dir);

  tlc_rr_pick #(
    .NUM_DIR(NUM_DIR)
  ) u_rr_pick (
    .car_req   (car_req),
    .active_dir(active_dir),
    .next_dir  (next_dir)
  );

`ifndef TLC_PED_EN
  assign ped_pend = 1'b0;
`endif

`ifdef TLC_PED_EN
  localparam logic [TMR_W-1:0] WALK_LD = TMR_W'(WALK_CYC - 1);
`endif

  // Lamp pattern is registered alongside the state so outputs never see car_req.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_GREEN;
      active_dir <= '0;
      timer      <= GREEN_LD;
      light      <= lamp('0, GREEN);
`ifdef TLC_PED_EN
      ped_pend   <= 1'b0;
      ped_walk   <= 1'b0;
`endif
    end else begin
      case (state)
        S_GREEN: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if ((|others) || ped_pend) begin
            state <= S_YELLOW;
            timer <= YELLOW_LD;
            light <= lamp(active_dir, YELLOW);
          end
        end
        S_YELLOW: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            state <= S_ALLRED;
            timer <= ALLRED_LD;
            light <= lamp(active_dir, RED);
          end
        end
        S_ALLRED: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end
`ifdef TLC_PED_EN
          else if (ped_pend) begin
            state    <= S_WALK;
            timer    <= WALK_LD;
            ped_walk <= 1'b1;
          end
`endif
          else begin
            state      <= S_GREEN;
            timer      <= GREEN_LD;
            active_dir <= next_dir;
            light      <= lamp(next_dir, GREEN);
          end
        end
`ifdef TLC_PED_EN
        S_WALK: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            state      <= S_GREEN;
            timer      <= GREEN_LD;
            active_dir <= next_dir;
            light      <= lamp(next_dir, GREEN);
            ped_walk   <= 1'b0;
          end
        end
`endif
        default: begin
          state <= S_GREEN;
          timer <= GREEN_LD;
          light <= lamp(active_dir, GREEN);
        end
      endcase

`ifdef TLC_PED_EN
      // Requests during walk are dropped, except on the final walk cycle.
      if (state == S_ALLRED && timer == '0 && ped_pend)
        ped_pend <= 1'b0;
      else if (state != S_WALK || timer == '0)
        ped_pend <= ped_pend | ped_req;
`endif
    end
  end

endmodule

`default_nettype wire
